tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 100 ++++++++++
 tb/tb_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that serialises one of four items per frame (head 1, item LSB first, trailer 0, one gap cycle).
// Head bit and ack appear one cycle after the grant edge; channel_busy only holds off new frames and never aborts one.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tx_arbiter #(
  parameter int routerid = -1,
  parameter     port     = "unknown"
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [3:0]                            req,
  input  logic [4*(`PAYLOAD_SIZE+`ADDR_SZ)-1:0] items,
  output logic [3:0]                            ack,
  input  logic                                  channel_busy,
  output logic                                  serial_out,
  output logic                                  busy
);

  localparam int W  = `PAYLOAD_SIZE + `ADDR_SZ;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state;
  logic [W+1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [1:0]     last_grant;
  logic [1:0]     cand;
  logic [1:0]     gnt_idx;
  logic           gnt_any;
  logic [W-1:0]   gnt_item;

  // Search starts just after the previous winner so every requester is served in turn.
  always_comb begin
    gnt_idx = last_grant;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_item = items[gnt_idx*W +: W];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      ack        <= '0;
      last_grant <= 2'd3;
    end else begin
      ack <= '0;
      case (state)
        // The gap cycle's closing edge may grant directly, giving W+3 grant-to-grant spacing.
        IDLE, GAP: begin
          if (gnt_any && !channel_busy) begin
            shreg      <= {1'b0, gnt_item, 1'b1};
            cnt        <= '0;
            serial_out <= 1'b1;
            ack        <= 4'b0001 << gnt_idx;
            last_grant <= gnt_idx;
            state      <= SEND;
          end else begin
            serial_out <= 1'b0;
            state      <= IDLE;
          end
        end
        SEND: begin
          if (cnt == CW'(W + 1)) begin
            state      <= GAP;
            serial_out <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
          end else begin
            shreg      <= shreg >> 1;
            serial_out <= shreg[1];
            cnt        <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, single frame, contention, back-pressure, reset mid-frame, loopback.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_tx_arbiter;

  localparam int W = `PAYLOAD_SIZE + `ADDR_SZ;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] items = '0;
  logic [3:0]     ack;
  logic           channel_busy = 1'b0;
  logic           serial_out;
  logic           busy;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  logic         rx_en = 1'b0;
  logic         rx_active = 1'b0;
  int           rx_idx = 0;
  logic [W-1:0] rx_word = '0;

  tx_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .items        (items),
    .ack          (ack),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Far-end receiver model: frames start on a 1, take W data bits, then the trailer.
  always @(negedge clk) begin
    if (rx_en) begin
      if (!rx_active) begin
        if (serial_out === 1'b1) begin
          rx_active = 1'b1;
          rx_idx = 0;
        end
      end else if (rx_idx < W) begin
        rx_word[rx_idx] = serial_out;
        rx_idx++;
      end else begin
        rx_active = 1'b0;
        rx_q.push_back(rx_word);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    channel_busy = 1'b0;
    step();
    step();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL reset_serial got=%b exp=0", serial_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req = 4'b0000;
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_idle_ack got=%b exp=0000", ack); end
  endtask

  task automatic test_single();
    logic [13:0] exp_bits;
    logic [3:0]  exp_ack;
    exp_bits = 14'b01010010100111;  // 1,1,1,0,0,1,0,1,0,0,1,0,1,0 read from bit 0 upward
    items = '0;
    items[11:0] = 12'hA53;
    req = 4'b0001;
    step();
    for (int k = 0; k < 14; k++) begin
      exp_ack = (k == 0) ? 4'b0001 : 4'b0000;
      checks++; if (serial_out !== exp_bits[k]) begin failures++; $display("FAIL single_bit k=%0d got=%b exp=%b", k, serial_out, exp_bits[k]); end
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL single_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy); end
      if (k == 0) req = 4'b0000;
      step();
    end
    checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL single_gap_serial got=%b exp=0", serial_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL single_idle_serial got=%b exp=0", serial_out); end
  endtask

  task automatic test_contention();
    int exp_order[5];
    int n;
    int last_cyc;
    int idx;
    logic [3:0] prev_ack;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) items[i*W +: W] = W'(12'h100 + i);
    step();
    reset = 1'b0;
    n = 0;
    last_cyc = 0;
    prev_ack = '0;
    for (int cyc = 0; cyc < 120 && n < 5; cyc++) begin
      step();
      if (prev_ack != 4'b0000 && ack != 4'b0000) begin
        checks++; failures++;
        $display("FAIL contention_consecutive_ack cyc=%0d prev=%b now=%b", cyc, prev_ack, ack);
      end
      if (ack != 4'b0000) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        checks++; if (!$onehot(ack)) begin failures++; $display("FAIL contention_onehot got=%b", ack); end
        checks++; if (idx != exp_order[n]) begin failures++; $display("FAIL contention_order n=%0d got=%0d exp=%0d", n, idx, exp_order[n]); end
        if (n > 0) begin
          checks++; if (cyc - last_cyc != 15) begin failures++; $display("FAIL contention_spacing n=%0d got=%0d exp=15", n, cyc - last_cyc); end
        end
        last_cyc = cyc;
        n++;
        if (n == 5) req = 4'b0000;
      end
      prev_ack = ack;
    end
    checks++; if (n != 5) begin failures++; $display("FAIL contention_count got=%0d exp=5", n); end
    req = 4'b0000;
    wait_idle("contention");
  endtask

  task automatic test_backpressure();
    channel_busy = 1'b1;
    req = 4'b0100;
    items[2*W +: W] = W'(12'h5A5);
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL bp_serial k=%0d got=%b exp=0", k, serial_out); end
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL bp_ack k=%0d got=%b exp=0000", k, ack); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy k=%0d got=%b exp=0", k, busy); end
    end
    channel_busy = 1'b0;
    step();
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL bp_release_ack got=%b exp=0100", ack); end
    checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL bp_release_head got=%b exp=1", serial_out); end
    req = 4'b0000;
    wait_idle("bp");
  endtask

  task automatic test_midframe_busy();
    logic [W+1:0] fr;
    logic [3:0]   exp_ack;
    items[W +: W] = W'(12'h3C5);
    fr = {1'b0, W'(12'h3C5), 1'b1};
    req = 4'b0010;
    channel_busy = 1'b0;
    step();
    for (int k = 0; k < W + 2; k++) begin
      exp_ack = (k == 0) ? 4'b0010 : 4'b0000;
      checks++; if (serial_out !== fr[k]) begin failures++; $display("FAIL mfb_bit k=%0d got=%b exp=%b", k, serial_out, fr[k]); end
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL mfb_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
      if (k == 4) channel_busy = 1'b1;
      step();
    end
    checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL mfb_gap_serial got=%b exp=0", serial_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mfb_gap_busy got=%b exp=1", busy); end
    step();
    for (int k = 0; k < 6; k++) begin
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL mfb_hold_ack k=%0d got=%b exp=0000", k, ack); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mfb_hold_busy k=%0d got=%b exp=0", k, busy); end
      step();
    end
    channel_busy = 1'b0;
    step();
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL mfb_regrant_ack got=%b exp=0010", ack); end
    req = 4'b0000;
    wait_idle("mfb");
  endtask

  task automatic test_reset_midframe();
    logic [W+1:0] fr;
    items[2*W +: W] = W'(12'h0F0);
    fr = {1'b0, W'(12'h0F0), 1'b1};
    req = 4'b0100;
    step();
    req = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      checks++; if (serial_out !== fr[k]) begin failures++; $display("FAIL rmf_bit k=%0d got=%b exp=%b", k, serial_out, fr[k]); end
      if (k < 6) step();
    end
    reset = 1'b1;
    req = 4'b1001;
    items[0 +: W] = W'(12'h111);
    items[3*W +: W] = W'(12'h888);
    step();
    checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL rmf_serial got=%b exp=0", serial_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmf_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rmf_ack got=%b exp=0000", ack); end
    reset = 1'b0;
    step();
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rmf_first_grant got=%b exp=0001", ack); end
    checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL rmf_first_head got=%b exp=1", serial_out); end
    req = 4'b0000;
    wait_idle("rmf");
  endtask

  task automatic test_loopback();
    int issued;
    int cyc;
    int n;
    issued = 0;
    cyc = 0;
    exp_q.delete();
    rx_q.delete();
    req = 4'b0000;
    channel_busy = 1'b0;
    wait_idle("lb_start");
    rx_en = 1'b1;
    while (rx_q.size() < 100 && cyc < 6000) begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          exp_q.push_back(items[i*W +: W]);
          req[i] = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && issued < 100 && $urandom_range(0, 3) == 0) begin
          items[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
          issued++;
        end
      end
      channel_busy = ($urandom_range(0, 4) == 0);
      step();
      cyc++;
    end
    rx_en = 1'b0;
    channel_busy = 1'b0;
    req = 4'b0000;
    checks++; if (rx_q.size() != 100) begin failures++; $display("FAIL lb_rx_count got=%0d exp=100", rx_q.size()); end
    checks++; if (exp_q.size() != 100) begin failures++; $display("FAIL lb_ack_count got=%0d exp=100", exp_q.size()); end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL lb_item i=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_midframe_busy();
    test_reset_midframe();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
